fifo_writer: RTL and testbench

//  Transmit side of the external byte-FIFO link. Accepts bytes from internal

---
 rtl/fifo_writer.sv | 144 ++++++++++++++
 tb/tb_fifo_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_writer.sv
// fifo_writer: transmit side of the external byte-FIFO link.
// Buffers bytes from a valid/ready source in a small queue. Each byte is then
// written into an external async FIFO with a setup / -W pulse / recovery
// sequence. All three phases are counted in clk cycles.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  WR_IDLE   | -W high; waits for a queued byte and a not-full flag
//  WR_SETUP  | data driven, -W high, for SETUP_TICKS cycles
//  WR_STROBE | -W low for PULSE_TICKS cycles; head popped on exit
//  WR_HOLD   | -W high, data held, for RECOVERY_TICKS cycles
module fifo_writer #(
  parameter int DEPTH          = 4,
  parameter int SETUP_TICKS    = 3,
  parameter int PULSE_TICKS    = 5,
  parameter int RECOVERY_TICKS = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       nff_in,
  output logic [7:0] fifo_data_out,
  output logic       fifo_wr_n,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] WR_IDLE   = 2'd0;
  localparam logic [1:0] WR_SETUP  = 2'd1;
  localparam logic [1:0] WR_STROBE = 2'd2;
  localparam logic [1:0] WR_HOLD   = 2'd3;

  localparam logic [3:0] SETUP_LAST    = 4'(SETUP_TICKS - 1);
  localparam logic [3:0] PULSE_LAST    = 4'(PULSE_TICKS - 1);
  localparam logic [3:0] RECOVERY_LAST = 4'(RECOVERY_TICKS - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [3:0]    tick;
  logic          nff;
  logic          pending;
  logic          push;
  logic          pop;
  logic          tick_done;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == WR_STROBE) & tick_done;
  assign busy     = (count != '0) | (state != WR_IDLE);

  // Terminal count of the phase currently being timed.
  always_comb begin
    tick_done = 1'b0;
    case (state)
      WR_SETUP:  tick_done = (tick == SETUP_LAST);
      WR_STROBE: tick_done = (tick == PULSE_LAST);
      WR_HOLD:   tick_done = (tick == RECOVERY_LAST);
      default:   tick_done = 1'b0;
    endcase
  end

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  // Queue pointers and occupancy, plus the registered full flag.
  // pending lags count by one edge so the head is read from settled storage,
  // never from the entry being written on the same edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pending <= 1'b0;
      nff     <= 1'b0;
    end else begin
      nff     <= nff_in;
      pending <= (count != '0);
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write sequencer: setup, -W pulse, recovery; tick restarts on each entry.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state         <= WR_IDLE;
      tick          <= '0;
      fifo_wr_n     <= 1'b1;
      fifo_data_out <= 8'd0;
    end else begin
      case (state)
        WR_IDLE: begin
          tick      <= '0;
          fifo_wr_n <= 1'b1;
          if (pending && nff) begin
            fifo_data_out <= mem[rptr];
            state         <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          if (tick_done) begin
            fifo_wr_n <= 1'b0;
            tick      <= '0;
            state     <= WR_STROBE;
          end else begin
            tick <= tick + 4'd1;
          end
        end
        WR_STROBE: begin
          if (tick_done) begin
            fifo_wr_n <= 1'b1;
            tick      <= '0;
            state     <= WR_HOLD;
          end else begin
            tick <= tick + 4'd1;
          end
        end
        default: begin
          if (tick_done) begin
            tick  <= '0;
            state <= WR_IDLE;
          end else begin
            tick <= tick + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_writer.sv
// tb_fifo_writer: directed scenarios plus random traffic against a
// write-schedule reference model of fifo_writer.
module tb_fifo_writer;

  localparam int DEPTH = 4;
  localparam int S     = 3;
  localparam int P     = 5;
  localparam int R     = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       nff_in = 1'b1;
  logic       in_ready;
  logic [7:0] fifo_data_out;
  logic       fifo_wr_n;
  logic       busy;

  fifo_writer #(
    .DEPTH(DEPTH), .SETUP_TICKS(S), .PULSE_TICKS(P), .RECOVERY_TICKS(R)
  ) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .nff_in(nff_in), .fifo_data_out(fifo_data_out),
    .fifo_wr_n(fifo_wr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model: a queue of accepted bytes and the start edge of the
  // current write; every output is derived from the start edge by arithmetic.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_start = 0;
  logic [7:0] m_data = 8'd0;
  bit         m_pending = 1'b0;
  bit         m_nff = 1'b0;
  bit         rst_edge = 1'b0;
  logic [7:0] exp_wr[$];
  logic [7:0] got_wr[$];
  int         run = 0;
  int         last_fall = -1;
  logic       prev_wr_n = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at edge %0d", tag, got, exp, t);
    end
  endtask

  task automatic model_edge();
    int sz = q.size();
    bit idle_before = !m_active || (t > m_start + S + P + R);
    rst_edge = !nrst;
    if (!nrst) begin
      q.delete();
      m_active  = 1'b0;
      m_data    = 8'd0;
      m_pending = 1'b0;
      m_nff     = 1'b0;
    end else begin
      if (idle_before && m_pending && m_nff && q.size() != 0) begin
        m_active = 1'b1;
        m_start  = t;
        m_data   = q[0];
      end else if (m_active && t == m_start + S + P) begin
        exp_wr.push_back(q[0]);
        void'(q.pop_front());
      end
      if (in_valid && sz < DEPTH) q.push_back(in_data);
      m_pending = (sz != 0);
      m_nff     = nff_in;
    end
  endtask

  task automatic compare();
    bit low = m_active && (t >= m_start + S) && (t < m_start + S + P);
    check("wr_n", fifo_wr_n, !low);
    check("data_out", fifo_data_out, m_data);
    check("in_ready", in_ready, q.size() < DEPTH);
    check("busy", busy, (q.size() != 0) || (m_active && t < m_start + S + P + R));
    if (rst_edge) begin
      run = 0;
    end else if (fifo_wr_n === 1'b0) begin
      if (prev_wr_n === 1'b1) last_fall = t;
      run++;
    end else if (run > 0) begin
      check("pulse_len", run, P);
      got_wr.push_back(fifo_data_out);
      run = 0;
    end
    prev_wr_n = fifo_wr_n;
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int rel;
    int k;

    // Reset
    nrst = 1'b0;
    nff_in = 1'b1;
    steps(3);
    nrst = 1'b1;
    steps(3);

    // Single byte timing
    t0 = t + 1;
    push_byte(8'hA5);
    while (t < t0 + 15) step();
    check("t1_fall_edge", last_fall - t0, 2 + S);
    check("t1_busy_15", busy, 1'b0);

    // Back-to-back overflow
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
    steps(80);

    // Held off by full flag
    nff_in = 1'b0;
    push_byte(8'h3C);
    last_fall = -1;
    steps(100);
    check("t3_no_pulse", last_fall, -1);
    check("t3_busy", busy, 1'b1);
    rel = t;
    nff_in = 1'b1;
    steps(30);
    check("t3_fall_edge", last_fall - rel, 2 + S);

    // Full flag rising during a strobe
    push_byte(8'h11);
    push_byte(8'h22);
    k = 0;
    while (k < 200 && !(m_active && m_data == 8'h11 && t >= m_start + S)) begin
      step();
      k++;
    end
    check("t4_reach_strobe", k < 200, 1'b1);
    nff_in = 1'b0;
    steps(40);
    nff_in = 1'b1;
    steps(30);

    // Reset in the third strobe cycle
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    k = 0;
    while (k < 200 && !(m_active && m_data == 8'h33 && t == m_start + S + 2)) begin
      step();
      k++;
    end
    check("t5_reach_strobe", k < 200, 1'b1);
    nrst = 1'b0;
    step();
    check("t5_rst_wr_n", fifo_wr_n, 1'b1);
    check("t5_rst_data", fifo_data_out, 8'd0);
    nrst = 1'b1;
    last_fall = -1;
    steps(40);
    check("t5_no_pulse", last_fall, -1);

    // Continuous offering: push on pop edges, pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      in_data = 8'(8'h80 + i);
      step();
    end
    in_valid = 1'b0;
    steps(70);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_data  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) nff_in = ($urandom_range(0, 99) < 75);
      nrst = ($urandom_range(0, 399) != 0);
      step();
    end
    nrst = 1'b1;
    in_valid = 1'b0;
    nff_in = 1'b1;
    steps(80);

    check("write_count", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check("write_order", got_wr[i], exp_wr[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
